// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and round-robin pick for the memory port arbiter
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_e;
   typedef enum logic {OWN_I, OWN_D} owner_e;

   // With both ports requesting, the port that did not win last time goes first.
   function automatic owner_e rr_pick(input logic i_req, input logic d_req, input owner_e last);
      if (i_req && d_req) begin
         return (last == OWN_I) ? OWN_D : OWN_I;
      end
      return d_req ? OWN_D : OWN_I;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, data and memory-side signals of the arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_cancel;
   logic [DATA_W-1:0] i_rdata;
   logic              i_valid;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_valid;
   logic              stall_f;
   logic              stall_m;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic              timeout_err;

   modport slave (
      input  i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      output i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata, timeout_err
   );

   modport master (
      output i_req, i_addr, i_cancel, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rdata,
      input  i_rdata, i_valid, d_rdata, d_valid, stall_f, stall_m,
             mem_req, mem_we, mem_addr, mem_wdata, timeout_err
   );
endinterface

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - counts enabled cycles and flags the TIMEOUT-th one
module mem_watchdog #(
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);
   localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT - 1);

   logic [TO_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && (r_cnt != LIMIT)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_expired = i_enable && (r_cnt == LIMIT);
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin fetch/data arbiter for a single-port memory
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255,
   parameter int TO_W    = 8
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   arb_state_e        r_state;
   owner_e            r_owner;
   owner_e            r_last;
   logic              r_cancel;
   logic              r_i_valid;
   logic              r_d_valid;
   logic              r_mem_req;
   logic              r_mem_we;
   logic              r_timeout;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [DATA_W-1:0] r_i_rdata;
   logic [DATA_W-1:0] r_d_rdata;

   owner_e w_pick;
   logic   w_any_req;
   logic   w_cancel_hit;
   logic   w_expired;
   logic   w_wd_en;
   logic   w_wd_clear;
   logic   w_i_valid;

   assign w_any_req  = bus.i_req || bus.d_req;
   assign w_pick     = rr_pick(bus.i_req, bus.d_req, r_last);
   assign w_wd_en    = (r_state == BUSY);
   assign w_wd_clear = !w_wd_en;
   // A cancel only matters when the fetch port owns, or is about to own, the memory.
   assign w_cancel_hit = bus.i_cancel &&
                         ((r_state == IDLE) ? (w_any_req && (w_pick == OWN_I)) : (r_owner == OWN_I));

   mem_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_watchdog (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_wd_clear),
      .i_enable  (w_wd_en),
      .o_expired (w_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_I;
         r_last      <= OWN_I;
         r_cancel    <= 1'b0;
         r_i_valid   <= 1'b0;
         r_d_valid   <= 1'b0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_timeout   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_i_rdata   <= '0;
         r_d_rdata   <= '0;
      end else begin
         r_i_valid <= 1'b0;
         r_d_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_owner     <= w_pick;
                  r_last      <= w_pick;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= (w_pick == OWN_D) && bus.d_we;
                  r_mem_addr  <= (w_pick == OWN_D) ? bus.d_addr : bus.i_addr;
                  r_mem_wdata <= (w_pick == OWN_D) ? bus.d_wdata : '0;
                  r_cancel    <= w_cancel_hit;
                  r_state     <= BUSY;
               end
            end
            BUSY: begin
               if (w_cancel_hit) begin
                  r_cancel <= 1'b1;
               end
               if (bus.mem_ready || w_expired) begin
                  r_mem_req <= 1'b0;
                  r_i_valid <= (r_owner == OWN_I) && !r_cancel && !bus.i_cancel;
                  r_d_valid <= (r_owner == OWN_D);
                  r_state   <= DONE;
                  // mem_ready wins over a watchdog expiry landing on the same cycle.
                  if (!bus.mem_ready) begin
                     r_timeout <= 1'b1;
                     if (r_owner == OWN_I) r_i_rdata <= '0;
                     else                  r_d_rdata <= '0;
                  end else if (r_owner == OWN_I) begin
                     r_i_rdata <= bus.mem_rdata;
                  end else if (!r_mem_we) begin
                     r_d_rdata <= bus.mem_rdata;
                  end
               end
            end
            DONE: begin
               r_cancel <= 1'b0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A flush arriving in the completion cycle still swallows the fetch pulse.
   assign w_i_valid = r_i_valid && !bus.i_cancel;

   assign bus.i_valid     = w_i_valid;
   assign bus.i_rdata     = r_i_rdata;
   assign bus.d_valid     = r_d_valid;
   assign bus.d_rdata     = r_d_rdata;
   assign bus.stall_f     = bus.i_req && !w_i_valid;
   assign bus.stall_m     = bus.d_req && !r_d_valid;
   assign bus.mem_req     = r_mem_req;
   assign bus.mem_we      = r_mem_we;
   assign bus.mem_addr    = r_mem_addr;
   assign bus.mem_wdata   = r_mem_wdata;
   assign bus.timeout_err = r_timeout;
endmodule
